// File: rtl/game_control_np.sv
// Game sequencer: attract -> start reset -> serve wait -> play, with N players and credits.
// GAME_CONTROL_AUTO_START_EN selects legacy behaviour where a coin starts the game directly.
module game_control_np #(
    parameter int CLK_HZ         = 7_159_000,
    parameter int SERVE_DELAY_MS = 1700,
    parameter int NUM_PLAYERS    = 2,
    parameter int CREDIT_W       = 4,
    parameter int MAX_CREDITS    = 9,
    parameter int SRST_CYCLES    = 16,
    localparam int PW            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                clk7_159,
    input  logic                rst,
    input  logic                coin_sw,
    input  logic                start_sw,
    input  logic                _miss,
    input  logic [PW-1:0]       miss_side,
    input  logic                stop_g,
    output logic [CREDIT_W-1:0] credits,
    output logic                srst,
    output logic                _srst,
    output logic                rst_speed,
    output logic                running,
    output logic                attract,
    output logic                _attract,
    output logic                serve,
    output logic                _serve,
    output logic [PW-1:0]       serve_side
);

    localparam int SERVE_CYCLES = CLK_HZ / 1000 * SERVE_DELAY_MS - 1;
    localparam int TMAX         = (SERVE_CYCLES > SRST_CYCLES - 1) ? SERVE_CYCLES : SRST_CYCLES - 1;
    localparam int TW           = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    localparam logic [PW:0]   NP_EXT      = (PW + 1)'(NUM_PLAYERS);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    typedef enum logic [1:0] {
        ST_ATTRACT,
        ST_SRST,
        ST_SERVE_WAIT,
        ST_PLAY
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [PW-1:0]       serve_side_q, serve_side_d;
    logic                rst_speed_q, rst_speed_d;
    logic                srst_q, srst_d;
    logic                running_q, running_d;
    logic                serve_q, serve_d;
    logic                coin_prev_q, start_prev_q, miss_prev_q, stop_prev_q;

    logic coin_edge, miss_edge, stop_edge;
    logic start_game, start_accept, coin_add;

    assign coin_edge = coin_sw & ~coin_prev_q;
    assign miss_edge = ~_miss & miss_prev_q;
    assign stop_edge = stop_g & ~stop_prev_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        serve_side_d = serve_side_q;
        rst_speed_d  = 1'b0;
        start_game   = 1'b0;
        start_accept = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
`ifdef GAME_CONTROL_AUTO_START_EN
                start_game = coin_edge;
`else
                if (start_sw && !start_prev_q && credits_q != '0) begin
                    start_game   = 1'b1;
                    start_accept = 1'b1;
                end
`endif
            end
            ST_SRST, ST_SERVE_WAIT: begin
                if (stop_edge) begin
                    state_d = ST_ATTRACT;
                end else if (timer_q == '0) begin
                    state_d = (state_q == ST_SRST) ? ST_SERVE_WAIT : ST_PLAY;
                    timer_d = (state_q == ST_SRST) ? TW'(SERVE_CYCLES) : timer_q;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_PLAY: begin
                if (stop_edge) begin
                    state_d = ST_ATTRACT;
                end else if (miss_edge) begin
                    state_d      = ST_SERVE_WAIT;
                    timer_d      = TW'(SERVE_CYCLES);
                    rst_speed_d  = 1'b1;
                    serve_side_d = ({1'b0, miss_side} >= NP_EXT) ? LAST_PLAYER : miss_side;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase

        if (start_game) begin
            state_d      = ST_SRST;
            timer_d      = TW'(SRST_CYCLES - 1);
            serve_side_d = '0;
            rst_speed_d  = 1'b1;
        end

        // The coin that auto-starts a game is spent on the game, not banked.
`ifdef GAME_CONTROL_AUTO_START_EN
        coin_add = coin_edge & ~start_game;
`else
        coin_add = coin_edge;
`endif
        credits_d = credits_q;
        if (coin_add && !start_accept) begin
            if (credits_q < CREDIT_W'(MAX_CREDITS))
                credits_d = credits_q + CREDIT_W'(1);
        end else if (!coin_add && start_accept) begin
            credits_d = credits_q - CREDIT_W'(1);
        end

        srst_d    = (state_d == ST_SRST);
        serve_d   = (state_d == ST_SERVE_WAIT);
        running_d = (state_d != ST_ATTRACT);
    end

    always_ff @(posedge clk7_159) begin
        if (rst) begin
            state_q      <= ST_ATTRACT;
            timer_q      <= '0;
            credits_q    <= '0;
            serve_side_q <= '0;
            rst_speed_q  <= 1'b0;
            srst_q       <= 1'b0;
            running_q    <= 1'b0;
            serve_q      <= 1'b0;
            coin_prev_q  <= 1'b0;
            start_prev_q <= 1'b0;
            miss_prev_q  <= 1'b1;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            credits_q    <= credits_d;
            serve_side_q <= serve_side_d;
            rst_speed_q  <= rst_speed_d;
            srst_q       <= srst_d;
            running_q    <= running_d;
            serve_q      <= serve_d;
            coin_prev_q  <= coin_sw;
            start_prev_q <= start_sw;
            miss_prev_q  <= _miss;
            stop_prev_q  <= stop_g;
        end
    end

    // attract follows the registered stop_g level so it stays up while game-over is held.
    assign credits    = credits_q;
    assign srst       = srst_q;
    assign _srst      = ~srst_q;
    assign rst_speed  = rst_speed_q;
    assign running    = running_q;
    assign attract    = ~running_q | stop_prev_q;
    assign _attract   = ~attract;
    assign serve      = serve_q;
    assign _serve     = ~serve_q;
    assign serve_side = serve_side_q;

endmodule

// File: tb/tb_game_control_np.sv
// Bench for game_control_np: vector table, directed corner sequences and a random run
// checked against a timeline model of the game (aware of GAME_CONTROL_AUTO_START_EN).
module tb_game_control_np;

    localparam int CLK_HZ         = 10_000;
    localparam int SERVE_DELAY_MS = 1;
    localparam int NUM_PLAYERS    = 3;
    localparam int CREDIT_W       = 4;
    localparam int MAX_CREDITS    = 9;
    localparam int SRST_CYCLES    = 16;
    localparam int PW             = 2;
    localparam int SERVE_LEN      = CLK_HZ / 1000 * SERVE_DELAY_MS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, coin_sw, start_sw, miss_n, stop_g;
    logic [PW-1:0]       miss_side;
    logic [CREDIT_W-1:0] credits;
    logic                srst, srst_n, rst_speed, running, attract, attract_n, serve, serve_n;
    logic [PW-1:0]       serve_side;

    game_control_np #(
        .CLK_HZ(CLK_HZ), .SERVE_DELAY_MS(SERVE_DELAY_MS), .NUM_PLAYERS(NUM_PLAYERS),
        .CREDIT_W(CREDIT_W), .MAX_CREDITS(MAX_CREDITS), .SRST_CYCLES(SRST_CYCLES)
    ) dut (
        .clk7_159(clk), .rst(rst), .coin_sw(coin_sw), .start_sw(start_sw),
        ._miss(miss_n), .miss_side(miss_side), .stop_g(stop_g),
        .credits(credits), .srst(srst), ._srst(srst_n), .rst_speed(rst_speed),
        .running(running), .attract(attract), ._attract(attract_n),
        .serve(serve), ._serve(serve_n), .serve_side(serve_side)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_srst, cnt_serve, cnt_rs;

    // Model: a game is a timeline. SRST covers SRST_CYCLES edges from t_game, serving covers
    // SERVE_LEN edges from t_serve, play follows. Phase 0..3 = attract, srst, serve, play.
    int m_cyc, m_in_game, m_t_game, m_t_serve, m_credits, m_side, m_rs;
    bit m_pc, m_ps, m_pm, m_pt;

    function automatic int phase_of(int e);
        if (m_in_game == 0)              return 0;
        if (e - m_t_game < SRST_CYCLES)  return 1;
        if (e - m_t_serve < SERVE_LEN)   return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_in_game = 0; m_t_game = 0; m_t_serve = 0;
        m_credits = 0; m_side = 0; m_rs = 0;
        m_pc = 0; m_ps = 0; m_pm = 1; m_pt = 0;
    endtask

    task automatic model_step(bit r, bit c, bit s, bit mn, int side, bit st);
        int p, e;
        bit ce, me, te, acc, start_game;
        if (r) begin
            model_reset();
            return;
        end
        p  = phase_of(m_cyc);
        e  = m_cyc + 1;
        ce = c && !m_pc;
        me = !mn && m_pm;
        te = st && !m_pt;
        acc = 0; start_game = 0; m_rs = 0;
        if (p != 0 && te) begin
            m_in_game = 0;
        end else if (p == 0) begin
`ifdef GAME_CONTROL_AUTO_START_EN
            start_game = ce;
`else
            if (s && !m_ps && m_credits > 0) begin
                start_game = 1; acc = 1;
            end
`endif
        end else if (p == 3 && me) begin
            m_t_serve = e;
            m_side    = (side >= NUM_PLAYERS) ? NUM_PLAYERS - 1 : side;
            m_rs      = 1;
        end
        if (start_game) begin
            m_in_game = 1; m_t_game = e; m_t_serve = e + SRST_CYCLES; m_side = 0; m_rs = 1;
        end
`ifdef GAME_CONTROL_AUTO_START_EN
        if (ce && !start_game) m_credits = m_credits + 1;
`else
        m_credits = m_credits + int'(ce) - int'(acc);
`endif
        if (m_credits > MAX_CREDITS) m_credits = MAX_CREDITS;
        m_pc = c; m_ps = s; m_pm = mn; m_pt = st;
        m_cyc = e;
    endtask

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkOutput(string tag);
        int ph;
        bit exp_attract;
        ph = phase_of(m_cyc);
        exp_attract = (ph == 0) || m_pt;
        chk({tag, " credits"},    int'(credits),    m_credits);
        chk({tag, " srst"},       int'(srst),       int'(ph == 1));
        chk({tag, " _srst"},      int'(srst_n),     int'(ph != 1));
        chk({tag, " rst_speed"},  int'(rst_speed),  m_rs);
        chk({tag, " running"},    int'(running),    int'(ph != 0));
        chk({tag, " attract"},    int'(attract),    int'(exp_attract));
        chk({tag, " _attract"},   int'(attract_n),  int'(!exp_attract));
        chk({tag, " serve"},      int'(serve),      int'(ph == 2));
        chk({tag, " _serve"},     int'(serve_n),    int'(ph != 2));
        chk({tag, " serve_side"}, int'(serve_side), m_side);
        cnt_srst  += int'(srst);
        cnt_serve += int'(serve);
        cnt_rs    += int'(rst_speed);
    endtask

    task automatic applyStimulus(bit r, bit c, bit s, bit mn, int side, bit st, string tag);
        @(negedge clk);
        rst = r; coin_sw = c; start_sw = s; miss_n = mn; miss_side = PW'(side); stop_g = st;
        @(posedge clk);
        model_step(r, c, s, mn, side, st);
        #1;
        checkOutput(tag);
    endtask

    task automatic clear_counts();
        cnt_srst = 0; cnt_serve = 0; cnt_rs = 0;
    endtask

    task automatic waitServeEnd(string tag);
        bit seen, done;
        seen = serve; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, tag);
            if (serve) seen = 1;
            else if (seen) done = 1;
        end
        chk({tag, " serve_end_within_bound"}, int'(done), 1);
    endtask

    typedef struct {
        bit r, c, s;
        int exp_credits;
        bit exp_running;
        bit exp_attract;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected %0d", 0);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        bit c, s, mn, st, r;
        rst = 1; coin_sw = 0; start_sw = 0; miss_n = 1; miss_side = '0; stop_g = 0;
        model_reset();
        clear_counts();

`ifndef GAME_CONTROL_AUTO_START_EN
        // Reset, an ignored start with no credits, then 12 coins saturating at 9.
        for (int i = 0; i < 3; i++) tbl.push_back('{1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 1});
        for (int k = 1; k <= 12; k++) begin
            tbl.push_back('{0, 1, 0, (k > 9) ? 9 : k, 0, 1});
            tbl.push_back('{0, 0, 0, (k > 9) ? 9 : k, 0, 1});
        end
        foreach (tbl[i]) begin
            v = tbl[i];
            applyStimulus(v.r, v.c, v.s, 1, 0, 0, "table");
            chk($sformatf("tbl%0d credits", i), int'(credits), v.exp_credits);
            chk($sformatf("tbl%0d running", i), int'(running), int'(v.exp_running));
            chk($sformatf("tbl%0d attract", i), int'(attract), int'(v.exp_attract));
        end

        // Start with 9 credits: srst 16 clocks, one speed reset, serve 10 clocks.
        clear_counts();
        applyStimulus(0, 0, 1, 1, 0, 0, "start");
        chk("start credits", int'(credits), 8);
        chk("start srst", int'(srst), 1);
        waitServeEnd("first_serve");
        chk("srst_len", cnt_srst, 16);
        chk("rst_speed_pulses", cnt_rs, 1);
        chk("serve_len", cnt_serve, SERVE_LEN);
        chk("play serve", int'(serve), 0);

        // Miss by player 1, then a miss while serving must not restart the timer.
        clear_counts();
        applyStimulus(0, 0, 0, 0, 1, 0, "miss1");
        chk("miss1 rst_speed", int'(rst_speed), 1);
        chk("miss1 serve", int'(serve), 1);
        chk("miss1 serve_side", int'(serve_side), 1);
        applyStimulus(0, 0, 0, 1, 1, 0, "miss1_rel");
        applyStimulus(0, 0, 0, 0, 2, 0, "miss_in_serve");
        applyStimulus(0, 0, 0, 1, 2, 0, "miss_in_serve_rel");
        waitServeEnd("second_serve");
        chk("second serve_len", cnt_serve, SERVE_LEN);
        chk("second rst_speed_pulses", cnt_rs, 1);

        // Out-of-range miss_side clamps to the last player.
        applyStimulus(0, 0, 0, 0, 3, 0, "miss_clamp");
        chk("clamp serve_side", int'(serve_side), NUM_PLAYERS - 1);
        applyStimulus(0, 0, 0, 1, 0, 0, "miss_clamp_rel");
        waitServeEnd("third_serve");

        // stop_g and miss in the same clock: game over wins.
        applyStimulus(0, 0, 0, 0, 1, 1, "stop_vs_miss");
        chk("stop running", int'(running), 0);
        chk("stop serve", int'(serve), 0);
        chk("stop attract", int'(attract), 1);
        applyStimulus(0, 0, 0, 1, 0, 1, "stop_held");
        chk("stop_held attract", int'(attract), 1);
        applyStimulus(0, 0, 0, 1, 0, 0, "stop_rel");

        // Coin and start together with 3 credits, then reset while serving.
        applyStimulus(1, 0, 0, 1, 0, 0, "reset2");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 0, "coin3");
            applyStimulus(0, 0, 0, 1, 0, 0, "coin3_rel");
        end
        applyStimulus(0, 1, 1, 1, 0, 0, "coin_and_start");
        chk("coin_start credits", int'(credits), 3);
        chk("coin_start running", int'(running), 1);
        for (int k = 0; k < 17; k++) applyStimulus(0, 0, 0, 1, 0, 0, "to_serve");
        chk("pre_reset serve", int'(serve), 1);
        applyStimulus(1, 0, 0, 1, 0, 0, "reset_mid");
        chk("reset_mid serve", int'(serve), 0);
        chk("reset_mid attract", int'(attract), 1);
        chk("reset_mid credits", int'(credits), 0);
`else
        // Coin starts the game directly; start_sw never does anything.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0, "reset");
        chk("reset attract", int'(attract), 1);
        chk("reset credits", int'(credits), 0);
        applyStimulus(0, 0, 1, 1, 0, 0, "start_ignored");
        applyStimulus(0, 0, 0, 1, 0, 0, "start_ignored_rel");
        chk("start_ignored running", int'(running), 0);
        applyStimulus(0, 1, 0, 1, 0, 0, "coin_start");
        chk("auto running", int'(running), 1);
        chk("auto srst", int'(srst), 1);
        chk("auto credits", int'(credits), 0);
        applyStimulus(0, 0, 1, 1, 0, 0, "start_in_game");
        applyStimulus(0, 0, 0, 1, 0, 1, "stop");
        chk("auto stop running", int'(running), 0);
        applyStimulus(0, 0, 0, 1, 0, 0, "stop_rel");
`endif

        // Random run against the model.
        c = 0; s = 0; mn = 1; st = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) c = ~c;
            if ($urandom_range(0, 6) == 0) s = ~s;
            if (mn) begin
                if ($urandom_range(0, 5) == 0) mn = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                mn = 1;
            end
            if ($urandom_range(0, 59) == 0) st = ~st;
            r = ($urandom_range(0, 299) == 0);
            applyStimulus(r, c, s, mn, int'($urandom_range(0, 3)), st, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_control_np.md
Name: game_control_np

Overview:
- Parametrised successor of the Pong game-control circuit. Adds N-player support, a saturating credit counter, a start button and a programmable serve delay.
- Sequences attract → start reset → serve wait → play → game over, and drives the global start reset, speed reset, attract and serve strobes.
- Sits between the coin/start inputs, the score logic (stop_g, miss) and the ball/paddle motion logic.

Parameters:
- CLK_HZ, 7_159_000: system clock frequency in Hz.
- SERVE_DELAY_MS, 1700: delay from miss (or game start) to ball release, in ms.
- NUM_PLAYERS, 2: number of players/paddles, 2..4.
- CREDIT_W, 4: credit counter width.
- MAX_CREDITS, 9: credit saturation value; must be ≤ 2^CREDIT_W-1.
- SRST_CYCLES, 16: length of the srst pulse in clocks, ≥1.

Ports:
- clk7_159, in, 1: system clock; all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- coin_sw, in, 1: coin switch, level; rising edge = one coin.
- start_sw, in, 1: start button, level; rising edge = start request.
- _miss, in, 1: active-low miss from the ball logic; falling edge = miss event.
- miss_side, in, PW: index of the player who missed, sampled with the miss event. PW = max(1, clog2(NUM_PLAYERS)).
- stop_g, in, 1: game-over from the score logic, level; rising edge ends the game.
- credits, out, CREDIT_W: current credit count.
- srst, out, 1: start reset pulse to the score counters.
- _srst, out, 1: ~srst.
- rst_speed, out, 1: one-clock pulse that resets ball speed.
- running, out, 1: game in progress.
- attract, out, 1: attract mode.
- _attract, out, 1: ~attract.
- serve, out, 1: ball held awaiting serve.
- _serve, out, 1: ~serve.
- serve_side, out, PW: player who serves next.

Behaviour:
- **Input edge detection:** registered previous values of coin_sw, start_sw, _miss and stop_g. Each event is one clock wide. The previous-value registers reset to 0, except _miss, which resets to 1. The first clock after reset therefore cannot fire a spurious event.
- **Credits:** +1 on a coin edge, saturating at MAX_CREDITS. −1 on an accepted start. A coin and an accepted start in the same clock leave credits unchanged. Coins are accepted in every state.
- **State machine:** ATTRACT, SRST, SERVE_WAIT, PLAY. Reset state is ATTRACT.
  - ATTRACT: a start edge with credits>0 consumes one credit and goes to SRST. A start edge with credits=0 is ignored.
  - SRST: srst=1 for SRST_CYCLES clocks, then go to SERVE_WAIT. serve_side loads 0 on entry.
  - SERVE_WAIT: serve=1. A down-counter is loaded with SERVE_CYCLES = CLK_HZ/1000*SERVE_DELAY_MS − 1 on entry. It reaches 0 after SERVE_CYCLES+1 clocks, then the FSM goes to PLAY and serve drops.
  - PLAY: a miss event goes to SERVE_WAIT and loads serve_side with miss_side. A miss_side ≥ NUM_PLAYERS is clamped to NUM_PLAYERS−1.
  - Any of SRST, SERVE_WAIT, PLAY: a stop_g edge returns to ATTRACT. stop_g has priority over a simultaneous miss or timer expiry.
- **rst_speed:** pulses for 1 clock on every miss event in PLAY and on the first clock of SRST.
- **running / attract:** running=1 in SRST, SERVE_WAIT and PLAY. attract = ~running | stop_g, so attract also shows while stop_g is held.
- **Miss outside PLAY:** a miss in SERVE_WAIT is ignored; the timer is not restarted.
- **Reset values:** credits=0, srst=0, _srst=1, rst_speed=0, running=0, attract=1, _attract=0, serve=0, _serve=1, serve_side=0, timer=0.
- **Reset mid-operation:** rst returns to the reset state in the next clock, regardless of state or timer value. Credits are lost.
- **Output timing:** all outputs are registered, or are direct combinational decodes of registered state; none are combinational from inputs.

Optional Feature:
- Macro: GAME_CONTROL_AUTO_START_EN.
- Defined: in ATTRACT, a coin edge immediately starts a game (ATTRACT→SRST). Credits are neither incremented nor decremented for that coin, and start_sw is ignored in every state. This is legacy coin-starts-game behaviour.
- Undefined: credit/start behaviour as described in Behaviour.

Test Plan:
1. **Reset values:** rst for 3 clocks → all outputs at reset values; attract=1, credits=0.
2. **Credit saturation and start:** 12 coin edges with MAX_CREDITS=9 → credits=9. A start edge → credits=8, srst high for exactly 16 clocks, rst_speed pulses once, serve=1.
3. **Serve timing:** overridden SERVE_DELAY_MS=1, CLK_HZ=10_000 → serve high for exactly 10 clocks, then PLAY with serve=0. A _miss falling edge with miss_side=1 → rst_speed 1-clock pulse, serve=1, serve_side=1.
4. **Priority and ignored events:** stop_g rising in the same clock as a _miss fall → ATTRACT, running=0, no serve. A start edge with credits=0 → stays in ATTRACT.
5. **Simultaneous coin/start and reset mid-game:** coin and start edges in the same clock with credits=3 → game starts, credits stays 3. rst asserted during SERVE_WAIT → next clock serve=0, attract=1, credits=0.
6. **Optional feature:** with GAME_CONTROL_AUTO_START_EN, a coin edge in ATTRACT → SRST, credits stays 0, and start_sw edges have no effect.
